// File: rtl/ring_control.sv
// ring_control: doorbell front end. Synchronises and debounces the doorbell,
// mode and track buttons, runs the ring-duration FSM and holds the mode and
// track selections. Optional feature macro: RING_RETRIGGER_EN (a doorbell
// press while ringing restarts the ring; otherwise such presses are ignored).
module ring_control #(
   parameter int unsigned DB_CYCLES   = 500000,
   parameter int unsigned RING_CYCLES = 268435456,
   parameter int unsigned MODE_MAX    = 4,
   parameter int unsigned TRCK_MAX    = 5
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_DRBL,
   input  logic       BTN_MODE,
   input  logic       BTN_TRCK,
   output logic       RING,
   output logic       RING_START,
   output logic       RING_DONE,
   output logic [2:0] MODE,
   output logic [2:0] TRCK,
   output logic       TRCK_CHG
);

   localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned RC_W  = $clog2(RING_CYCLES);
   localparam int unsigned NBTN  = 3;
   localparam int unsigned B_DRBL = 0;
   localparam int unsigned B_MODE = 1;
   localparam int unsigned B_TRCK = 2;

   typedef enum logic {IDLE = 1'b0, RINGING = 1'b1} state_t;

   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] sync1_q;
   logic [NBTN-1:0] sync2_q;
   logic [NBTN-1:0] db_q;
   logic [NBTN-1:0] db_prev_q;
   logic [NBTN-1:0] press_q;

   state_t          state_q;
   logic [RC_W-1:0] ring_cnt_q;
   logic            ring_q;
   logic            ring_start_q;
   logic            ring_done_q;
   logic [2:0]      mode_q;
   logic [2:0]      trck_q;
   logic            trck_chg_q;

   assign btn_raw = {BTN_TRCK, BTN_MODE, BTN_DRBL};

   // Two-flop synchronisers for the asynchronous button inputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar b = 0; b < NBTN; b++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic            lvl_q;

      // Accept a level change only after it has been stable for DB_CYCLES
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else if (sync2_q[b] != lvl_q) begin
            if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
               lvl_q <= ~lvl_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + DB_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end

      assign db_q[b] = lvl_q;
   end

   // Registered one-cycle press events on debounced rising edges
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         db_prev_q <= '0;
         press_q   <= '0;
      end else begin
         db_prev_q <= db_q;
         press_q   <= db_q & ~db_prev_q;
      end
   end

   // Mode and track selection registers, wrapping back to 1
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mode_q     <= 3'd1;
         trck_q     <= 3'd1;
         trck_chg_q <= 1'b0;
      end else begin
         trck_chg_q <= press_q[B_TRCK];
         if (press_q[B_MODE]) begin
            mode_q <= (mode_q == 3'(MODE_MAX)) ? 3'd1 : mode_q + 3'd1;
         end
         if (press_q[B_TRCK]) begin
            trck_q <= (trck_q == 3'(TRCK_MAX)) ? 3'd1 : trck_q + 3'd1;
         end
      end
   end

   // Ring-duration FSM with registered level and pulse outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         ring_cnt_q   <= '0;
         ring_q       <= 1'b0;
         ring_start_q <= 1'b0;
         ring_done_q  <= 1'b0;
      end else begin
         ring_start_q <= 1'b0;
         ring_done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (press_q[B_DRBL]) begin
                  state_q      <= RINGING;
                  ring_cnt_q   <= '0;
                  ring_q       <= 1'b1;
                  ring_start_q <= 1'b1;
               end
            end
            RINGING: begin
`ifdef RING_RETRIGGER_EN
               if (press_q[B_DRBL]) begin
                  ring_cnt_q   <= '0;
                  ring_start_q <= 1'b1;
               end else
`endif
               if (ring_cnt_q == RC_W'(RING_CYCLES - 1)) begin
                  state_q     <= IDLE;
                  ring_cnt_q  <= '0;
                  ring_q      <= 1'b0;
                  ring_done_q <= 1'b1;
               end else begin
                  ring_cnt_q <= ring_cnt_q + RC_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               ring_q  <= 1'b0;
            end
         endcase
      end
   end

   assign RING       = ring_q;
   assign RING_START = ring_start_q;
   assign RING_DONE  = ring_done_q;
   assign MODE       = mode_q;
   assign TRCK       = trck_q;
   assign TRCK_CHG   = trck_chg_q;

endmodule

// File: tb/tb_ring_control.sv
// Testbench for ring_control: directed and randomized button waveforms,
// expected events derived from press timing, scoreboard monitor.
module tb_ring_control;

   localparam int DB = 4;
   localparam int RC = 16;
   localparam int MM = 4;
   localparam int TM = 5;
   localparam int NC = 8000;
   localparam int LAT = DB + 3;

   logic       CLK = 1'b0;
   logic       RST;
   logic       BTN_DRBL, BTN_MODE, BTN_TRCK;
   logic       RING, RING_START, RING_DONE, TRCK_CHG;
   logic [2:0] MODE, TRCK;

   ring_control #(.DB_CYCLES(DB), .RING_CYCLES(RC), .MODE_MAX(MM), .TRCK_MAX(TM)) dut (
      .CLK(CLK), .RST(RST), .BTN_DRBL(BTN_DRBL), .BTN_MODE(BTN_MODE), .BTN_TRCK(BTN_TRCK),
      .RING(RING), .RING_START(RING_START), .RING_DONE(RING_DONE),
      .MODE(MODE), .TRCK(TRCK), .TRCK_CHG(TRCK_CHG)
   );

   always #5 CLK = ~CLK;

   typedef struct {int e; int v;} ev_t;

   bit   raw_d [NC];
   bit   raw_m [NC];
   bit   raw_t [NC];
   bit   ring_x [NC];
   int   q_start[$];
   int   q_done[$];
   ev_t  q_mode[$];
   ev_t  q_trck[$];
   int   pos = 0;
   int   m_mode = 1, m_trck = 1;
   int   r_begin = 0, r_end = 0;
   bit   r_live = 1'b0;
   int   checks = 0, errors = 0;
   int   edge_idx = -1;
   bit   run = 1'b0;
   int   prev_mode = 1, prev_trck = 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_idx);
      end
   endtask

   task automatic close_ring();
      q_done.push_back(r_end);
      for (int k = r_begin; k < r_end; k++) ring_x[k] = 1'b1;
      r_live = 1'b0;
   endtask

   // Doorbell press takes effect at edge p
   task automatic door(input int p);
      if (r_live && p <= r_end) begin
`ifdef RING_RETRIGGER_EN
         q_start.push_back(p);
         r_end = p + RC;
`endif
      end else begin
         if (r_live) close_ring();
         q_start.push_back(p);
         r_begin = p;
         r_end   = p + RC;
         r_live  = 1'b1;
      end
   endtask

   // Append a segment: buttons in mask high for hi cycles, then all low for lo
   task automatic seg(input int mask, input int hi, input int lo);
      int p;
      ev_t ev;
      if (pos + hi + lo > NC - 100) return;
      for (int i = 0; i < hi; i++) begin
         raw_d[pos+i] = mask[0];
         raw_m[pos+i] = mask[1];
         raw_t[pos+i] = mask[2];
      end
      if (hi >= DB) begin
         p = pos + LAT;
         if (mask[0]) door(p);
         if (mask[1]) begin
            m_mode = (m_mode == MM) ? 1 : m_mode + 1;
            ev.e = p; ev.v = m_mode; q_mode.push_back(ev);
         end
         if (mask[2]) begin
            m_trck = (m_trck == TM) ? 1 : m_trck + 1;
            ev.e = p; ev.v = m_trck; q_trck.push_back(ev);
         end
      end
      pos += hi + lo;
   endtask

   // Scoreboard monitor: pops expected events whenever the DUT shows one
   always @(negedge CLK) begin
      ev_t ev;
      int  e;
      if (run) begin
         if (edge_idx >= 0) check("ring_level", int'(RING), int'(ring_x[edge_idx]));
         if (RING_START) begin
            if (q_start.size() == 0) begin
               checks++; errors++;
               $display("FAIL ring_start_unexpected: got pulse expected none (edge %0d)", edge_idx);
            end else begin
               e = q_start.pop_front();
               check("ring_start_edge", edge_idx, e);
            end
         end
         if (RING_DONE) begin
            if (q_done.size() == 0) begin
               checks++; errors++;
               $display("FAIL ring_done_unexpected: got pulse expected none (edge %0d)", edge_idx);
            end else begin
               e = q_done.pop_front();
               check("ring_done_edge", edge_idx, e);
            end
         end
         if (TRCK_CHG || int'(TRCK) != prev_trck) begin
            check("trck_chg_coincident", int'(TRCK_CHG), int'(int'(TRCK) != prev_trck));
            if (q_trck.size() == 0) begin
               checks++; errors++;
               $display("FAIL trck_unexpected: got %0d expected no change (edge %0d)", TRCK, edge_idx);
            end else begin
               ev = q_trck.pop_front();
               check("trck_edge", edge_idx, ev.e);
               check("trck_value", int'(TRCK), ev.v);
            end
         end
         if (int'(MODE) != prev_mode) begin
            if (q_mode.size() == 0) begin
               checks++; errors++;
               $display("FAIL mode_unexpected: got %0d expected no change (edge %0d)", MODE, edge_idx);
            end else begin
               ev = q_mode.pop_front();
               check("mode_edge", edge_idx, ev.e);
               check("mode_value", int'(MODE), ev.v);
            end
         end
         prev_mode = int'(MODE);
         prev_trck = int'(TRCK);
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_ring"}, int'(RING), 0);
      check({tag, "_ring_start"}, int'(RING_START), 0);
      check({tag, "_ring_done"}, int'(RING_DONE), 0);
      check({tag, "_trck_chg"}, int'(TRCK_CHG), 0);
      check({tag, "_mode"}, int'(MODE), 1);
      check({tag, "_trck"}, int'(TRCK), 1);
   endtask

   initial begin
      int done_seen, ring_seen;
      RST = 1'b1;
      BTN_DRBL = 1'b0; BTN_MODE = 1'b0; BTN_TRCK = 1'b0;

      // Directed segments
      seg(1, 3, 12);                        // glitch: no event
      seg(1, 20, 30);                       // held doorbell: one ring
      for (int i = 0; i < 5; i++) seg(2, 5, 8);   // mode wrap
      for (int i = 0; i < 5; i++) seg(4, 5, 8);   // track wrap
      seg(6, 6, 10);                        // mode and track together
      seg(1, 5, 5);                         // ring, then second press
      seg(1, 5, 40);                        // 10 cycles into the ring
      // Randomized segments
      for (int i = 0; i < 150; i++)
         seg(int'($urandom_range(1, 7)), int'($urandom_range(1, DB + 8)),
             int'($urandom_range(DB + 1, DB + 14)));
      seg(0, 0, RC + 40);
      if (r_live) close_ring();

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      check_reset_values("reset_init");

      run = 1'b1;
      for (int n = 0; n < pos; n++) begin
         BTN_DRBL = raw_d[n];
         BTN_MODE = raw_m[n];
         BTN_TRCK = raw_t[n];
         @(posedge CLK);
         edge_idx = n;
         @(negedge CLK);
      end
      #1 run = 1'b0;

      check("start_queue_left", q_start.size(), 0);
      check("done_queue_left", q_done.size(), 0);
      check("mode_queue_left", q_mode.size(), 0);
      check("trck_queue_left", q_trck.size(), 0);

      // Asynchronous reset in the middle of a ring
      BTN_DRBL = 1'b1;
      repeat (6) @(negedge CLK);
      BTN_DRBL = 1'b0;
      for (int i = 0; i < 30 && !RING; i++) @(negedge CLK);
      check("ring_before_reset", int'(RING), 1);
      repeat (3) @(negedge CLK);
      #2 RST = 1'b1;
      #1 check_reset_values("reset_mid_ring");
      @(negedge CLK);
      RST = 1'b0;
      done_seen = 0;
      ring_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         done_seen += int'(RING_DONE);
         ring_seen += int'(RING);
      end
      check("no_done_after_reset", done_seen, 0);
      check("no_ring_after_reset", ring_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ring_control.md
Name: ring_control

Overview:
- Front-end stage of the doorbell; directly feeds the chime/LED/display/LCD stage.
- Synchronises and debounces the three push-buttons (doorbell, mode, track) and turns presses into single-cycle events.
- Runs the ring-duration state machine and holds the mode and track selections.
- Outputs are the ring-active level, the mode and track codes, and event pulses that the downstream stage consumes directly.

Parameters:
- DB_CYCLES, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).
- RING_CYCLES, 268435456: ring duration in clocks (about 5.37 s at 50 MHz). Must be ≥2.
- MODE_MAX, 4: highest mode code. Mode cycles 1..MODE_MAX.
- TRCK_MAX, 5: highest track code. Track cycles 1..TRCK_MAX.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-high reset.
- BTN_DRBL  in  1  raw doorbell button, active-high, asynchronous.
- BTN_MODE  in  1  raw mode button, active-high, asynchronous.
- BTN_TRCK  in  1  raw track button, active-high, asynchronous.
- RING  out  1  high while ringing.
- RING_START  out  1  one-cycle pulse when a ring starts or restarts.
- RING_DONE  out  1  one-cycle pulse when a ring times out.
- MODE  out  3  current mode, 1..MODE_MAX.
- TRCK  out  3  current track, 1..TRCK_MAX.
- TRCK_CHG  out  1  one-cycle pulse in the cycle TRCK changes; used to restart the LCD refresh.

Behaviour:
- Reset: one clock, CLK. RST is asynchronous and active-high; all flops clear immediately and RST is released synchronously by the system.
  - Reset values: RING=0, RING_START=0, RING_DONE=0, TRCK_CHG=0, MODE=1, TRCK=1.
  - Synchronisers and debounced levels reset to 0. Counters reset to 0. FSM resets to IDLE.
- Input sync: each BTN_* passes through a 2-flop synchroniser.
- Debounce (per button):
  - A counter increments each cycle the synchronised level differs from the debounced level.
  - The counter clears whenever the two levels match.
  - When the counter reaches DB_CYCLES-1 and the mismatch persists, the debounced level flips and the counter clears.
  - Any glitch shorter than DB_CYCLES clears the counter and produces no event.
- Press event: rising edge of the debounced level, one cycle wide.
  - Latency: the press event is seen by the logic DB_CYCLES+3 clocks after the first CLK edge that samples the raw input high.
  - Releases produce no event.
  - A held button gives exactly one press.
- Ring FSM, states IDLE and RINGING:
  - IDLE + doorbell press → RINGING; ring counter=0; RING_START=1 for one cycle.
  - RINGING: RING=1; counter increments each cycle.
  - When counter==RING_CYCLES-1 → IDLE; counter=0; RING_DONE=1 for one cycle. RING is therefore high for exactly RING_CYCLES cycles.
  - Doorbell press while RINGING: behaviour set by the optional feature below.
  - Counter width: ceil(log2(RING_CYCLES)) bits; the counter never wraps.
- Mode register:
  - Mode press: MODE = (MODE==MODE_MAX) ? 1 : MODE+1.
  - Updates in the cycle after the press event.
- Track register:
  - Track press: TRCK = (TRCK==TRCK_MAX) ? 1 : TRCK+1.
  - TRCK_CHG pulses in the same cycle TRCK takes its new value.
- Simultaneous events: mode, track and doorbell presses in the same cycle are all honoured independently.
- Selection changes during a ring: mode and track changes are accepted in any state. RING is unaffected.
- Registered outputs: all outputs come straight from flops; none is combinational from inputs.
- Reset mid-ring: RING drops asynchronously. RING_DONE is not produced.

Optional Feature:
- Macro: RING_RETRIGGER_EN.
- Defined:
  - A doorbell press while RINGING resets the counter to 0, stays in RINGING and pulses RING_START.
  - If the press coincides with the terminal cycle, retrigger wins: no RING_DONE, RING stays high.
- Undefined: doorbell presses while RINGING are ignored (no RING_START), and the ring ends at its original time.

Test Plan (DB_CYCLES=4, RING_CYCLES=16, MODE_MAX=4, TRCK_MAX=5):
- Reset check: assert RST mid-run, hold BTN_* low → MODE=1, TRCK=1, RING=0, all pulses 0 immediately, before any CLK edge.
- Glitch rejection: BTN_DRBL high for 3 cycles, then low → no RING_START, RING stays 0.
- Basic ring: BTN_DRBL held high 20 cycles → exactly one RING_START, 7 clocks after the first high sample; RING high 16 cycles; RING_DONE in the cycle RING falls; no second ring while the button is still held.
- Mode wrap: 5 clean mode presses → MODE sequence 2,3,4,1,2; one update per press.
- Track wrap: 5 clean track presses → TRCK 2,3,4,5,1; TRCK_CHG exactly 5 pulses, each coincident with the change. Pressing mode and track in the same cycle → both update in the same cycle.
- Retrigger: second doorbell press 10 cycles into a ring.
  - With RING_RETRIGGER_EN: RING_START pulses again and RING stays high 16 cycles from the retrigger.
  - Without it: RING falls 16 cycles after the first start, with a single RING_START.
